// File: rtl/handshake_fifo_buffer_pkg.sv
// Shared handshake helpers: pointer/count width functions and the transfer condition.
package handshake_fifo_buffer_pkg;

  // Width of a pointer that indexes n slots (at least one bit).
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of an occupancy counter that must represent 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  // A token moves when valid and ready are both high at the rising edge.
  function automatic logic hs_transfer(input logic valid, input logic ready);
    return valid & ready;
  endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Modulo-NUM_SLOTS pointer register; wraps from NUM_SLOTS-1 to 0 for any depth.
module handshake_fifo_ptr
  import handshake_fifo_buffer_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int WIDTH     = ptr_width(NUM_SLOTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_SLOTS - 1);

  // Advance the pointer on enable, wrapping explicitly at the last slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= {WIDTH{1'b0}};
    end else if (adv) begin
      ptr <= (ptr == LAST) ? {WIDTH{1'b0}} : ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/handshake_fifo_buffer.sv
// Opaque elastic FIFO for the handshake fabric: outputs depend only on registered state.
module handshake_fifo_buffer
  import handshake_fifo_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready
);

  localparam int PW = ptr_width(NUM_SLOTS);
  localparam int CW = cnt_width(NUM_SLOTS);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] storage [NUM_SLOTS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  en_q;
  logic                  push;
  logic                  pop;

  // Readiness and validity come from registers only, so no input reaches an output.
  assign ins_ready  = en_q & (count != FULL);
  assign outs_valid = (count != {CW{1'b0}});
  assign outs       = storage[rd_ptr];

  assign push = hs_transfer(ins_valid, ins_ready);
  assign pop  = hs_transfer(outs_valid, outs_ready);

  handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS), .WIDTH(PW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .adv (push),
    .ptr (wr_ptr)
  );

  handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS), .WIDTH(PW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .adv (pop),
    .ptr (rd_ptr)
  );

  // Out-of-reset flag: holds ins_ready low until the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q <= 1'b0;
    end else begin
      en_q <= 1'b1;
    end
  end

  // Token storage: cleared on reset, written only at the write pointer on push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        storage[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (push) begin
      storage[wr_ptr] <= ins;
    end
  end

  // Occupancy: up on push only, down on pop only, hold when both or neither.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= {CW{1'b0}};
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_fifo_buffer.sv
// Directed scoreboard bench: a 4-slot and a 3-slot buffer, expected tokens queued at issue.
module tb_handshake_fifo_buffer;

  logic        clk;
  logic        rst4, rst3;
  logic [31:0] in4, in3, o4, o3;
  logic        v4, v3, ir4, ir3, ov4, ov3, or4, or3;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q4[$];
  logic [31:0] q3[$];

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut4 (
    .clk(clk), .rst(rst4), .ins(in4), .ins_valid(v4), .ins_ready(ir4),
    .outs(o4), .outs_valid(ov4), .outs_ready(or4)
  );

  handshake_fifo_buffer #(.DATA_WIDTH(32), .NUM_SLOTS(3)) dut3 (
    .clk(clk), .rst(rst3), .ins(in3), .ins_valid(v3), .ins_ready(ir3),
    .outs(o3), .outs_valid(ov3), .outs_ready(or3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every upcoming output transfer must match the oldest expected token.
  always @(negedge clk) begin
    if (ov4 === 1'b1 && or4 === 1'b1) begin
      if (q4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon4_extra: got 0x%0h expected no token", o4);
      end else begin
        check("mon4_data", o4, q4.pop_front());
      end
    end
    if (ov3 === 1'b1 && or3 === 1'b1) begin
      if (q3.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mon3_extra: got 0x%0h expected no token", o3);
      end else begin
        check("mon3_data", o3, q3.pop_front());
      end
    end
  end

  initial begin
    rst4 = 1'b0; rst3 = 1'b0;
    in4 = 32'h0; v4 = 1'b0; or4 = 1'b0;
    in3 = 32'h0; v3 = 1'b0; or3 = 1'b0;

    // 1. reset and release
    repeat (3) begin
      tick();
      check("rst_outs_valid", {31'h0, ov4}, 32'h0);
      check("rst_outs", o4, 32'h0);
      check("rst_ins_ready", {31'h0, ir4}, 32'h0);
    end
    check("rst3_ins_ready", {31'h0, ir3}, 32'h0);
    rst4 = 1'b1; rst3 = 1'b1;
    #1;
    check("rel_ready_before_edge", {31'h0, ir4}, 32'h0);
    tick();
    check("rel_ready_after_edge", {31'h0, ir4}, 32'h1);
    check("rel3_ready_after_edge", {31'h0, ir3}, 32'h1);

    // 2. single token
    in4 = 32'h39; v4 = 1'b1; or4 = 1'b1;
    check("single_accept", {31'h0, ir4}, 32'h1);
    q4.push_back(32'h39);
    tick();
    v4 = 1'b0;
    check("single_valid", {31'h0, ov4}, 32'h1);
    check("single_data", o4, 32'h39);
    tick();
    check("single_empty_after", {31'h0, ov4}, 32'h0);

    // 3. fill to full, reject the fifth, drain in order
    or4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in4 = 32'h39 + i; v4 = 1'b1;
      check("fill_accept", {31'h0, ir4}, 32'h1);
      q4.push_back(32'h39 + i);
      tick();
    end
    check("full_ready_low", {31'h0, ir4}, 32'h0);
    in4 = 32'h3D;
    tick();
    check("full_fifth_rejected", {31'h0, ir4}, 32'h0);
    tick();
    v4 = 1'b0; or4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", {31'h0, ov4}, 32'h1);
      tick();
    end
    check("drain_empty", {31'h0, ov4}, 32'h0);

    // 4. streaming at full rate
    for (int i = 0; i < 20; i++) begin
      in4 = 32'h100 + i; v4 = 1'b1;
      check("stream_ready", {31'h0, ir4}, 32'h1);
      if (i > 0) check("stream_valid", {31'h0, ov4}, 32'h1);
      q4.push_back(32'h100 + i);
      tick();
    end
    v4 = 1'b0;
    check("stream_last_valid", {31'h0, ov4}, 32'h1);
    tick();
    check("stream_empty", {31'h0, ov4}, 32'h0);

    // 5. full with simultaneous offer: pop only, then refill
    or4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in4 = 32'h200 + i; v4 = 1'b1;
      q4.push_back(32'h200 + i);
      tick();
    end
    in4 = 32'h204; v4 = 1'b1; or4 = 1'b1;
    check("full_offer_ready", {31'h0, ir4}, 32'h0);
    tick();
    check("full_ready_after_pop", {31'h0, ir4}, 32'h1);
    q4.push_back(32'h204);
    or4 = 1'b0;
    tick();
    check("refull_ready_low", {31'h0, ir4}, 32'h0);
    v4 = 1'b0; or4 = 1'b1;
    repeat (4) tick();
    check("refull_drained", {31'h0, ov4}, 32'h0);
    or4 = 1'b0;

    // 6. three-slot buffer: wrap pointers, hold two tokens, async reset
    for (int i = 0; i < 3; i++) begin
      in3 = 32'hA0 + i; v3 = 1'b1;
      q3.push_back(32'hA0 + i);
      tick();
    end
    v3 = 1'b0; or3 = 1'b1;
    repeat (3) tick();
    check("wrap_drained", {31'h0, ov3}, 32'h0);
    or3 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in3 = 32'hA3 + i; v3 = 1'b1;
      q3.push_back(32'hA3 + i);
      tick();
    end
    v3 = 1'b0;
    check("hold_two_valid", {31'h0, ov3}, 32'h1);
    check("hold_two_head", o3, 32'hA3);
    #2;
    rst3 = 1'b0;
    q3.delete();
    #1;
    check("async_rst_valid", {31'h0, ov3}, 32'h0);
    check("async_rst_outs", o3, 32'h0);
    check("async_rst_ready", {31'h0, ir3}, 32'h0);
    tick();
    rst3 = 1'b1;
    tick();
    check("rerel_ready", {31'h0, ir3}, 32'h1);
    in3 = 32'h55; v3 = 1'b1; or3 = 1'b1;
    q3.push_back(32'h55);
    tick();
    v3 = 1'b0;
    check("post_rst_valid", {31'h0, ov3}, 32'h1);
    check("post_rst_data", o3, 32'h55);
    tick();
    check("post_rst_empty", {31'h0, ov3}, 32'h0);

    tick();
    check("q4_all_seen", q4.size(), 32'h0);
    check("q3_all_seen", q3.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_buffer.md
Name: handshake_fifo_buffer

Overview:
- Opaque elastic FIFO buffer for the dataflow handshake fabric.
- Sits directly downstream of constant/source stages (ctrl-triggered constants) and upstream of their consumers.
- Breaks combinational valid/ready paths and absorbs backpressure: NUM_SLOTS tokens of DATA_WIDTH bits with registered outputs.
- Same valid/ready channel semantics as every other handshake_* unit: a transfer occurs on a cycle where valid and ready are both 1 at the rising clk edge.

Parameters:
- DATA_WIDTH, 32, width of the token payload.
- NUM_SLOTS, 4, FIFO depth in tokens. Legal range is 2..256; any value, not only powers of two.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted). Assertion takes effect immediately; release is synchronised by the integrator.
- ins  input  DATA_WIDTH  input token payload.
- ins_valid  input  1  upstream offers a token.
- ins_ready  output  1  buffer can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-queue payload.
- outs_valid  output  1  head token present.
- outs_ready  input  1  downstream accepts the head token.

Behaviour:
- State:
  - storage array of NUM_SLOTS x DATA_WIDTH;
  - wr_ptr and rd_ptr, each clog2(NUM_SLOTS) bits;
  - count, clog2(NUM_SLOTS+1) bits;
  - en_q, a 1-bit "out of reset" flag.
- Reset (rst=0, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, every storage slot=0, en_q=0.
  - Hence outs=0, outs_valid=0, ins_ready=0.
- en_q goes to 1 on the first rising clk edge after rst returns to 1, and stays 1. ins_ready is therefore 1 from the second edge after release.
- ins_ready = en_q & (count != NUM_SLOTS).
  - Depends only on registered state; no combinational path from outs_ready.
- outs_valid = (count != 0). outs = storage[rd_ptr].
  - No combinational path from any input to any output.
- push = ins_valid & ins_ready. pop = outs_valid & outs_ready.
- On push: storage[wr_ptr] <= ins; wr_ptr advances.
- On pop: rd_ptr advances.
- Pointer wrap: a pointer equal to NUM_SLOTS-1 advances to 0; otherwise it increments by 1. There is no power-of-two assumption.
- count update:
  - push only: +1;
  - pop only: -1;
  - both or neither: unchanged.
- Latency: a token pushed at edge N is visible on outs/outs_valid after edge N (first cycle N+1). Minimum latency 1 cycle; no bypass.
- Throughput: one token per cycle sustained whenever 0 < count < NUM_SLOTS.
- Full (count = NUM_SLOTS):
  - ins_ready=0 even if outs_ready=1 in that cycle.
  - A pop frees the slot for the next cycle only.
- Empty (count = 0):
  - outs_valid=0; outs_ready is ignored.
  - A push in this cycle appears on the next cycle.
- Simultaneous push and pop at 0 < count < NUM_SLOTS: both pointers advance and count holds.
- Ordering: strict FIFO; payloads are never reordered, duplicated or dropped.
- Reset mid-operation: all queued tokens are discarded immediately and the outputs go to their reset values asynchronously.
- Upstream holding ins_valid=1 while ins_ready=0 must keep ins stable (fabric rule). The buffer only samples ins on push.

Decomposition:
- Shared handshake package holds:
  - ptr_width(n) and cnt_width(n) helper functions (clog2-based);
  - the handshake transfer-condition macro/function used by all handshake_* units.
- One natural sub-module: handshake_fifo_ptr, a modulo-NUM_SLOTS pointer register with advance enable and async active-low reset. It is instantiated twice, for wr_ptr and rd_ptr.
- Storage and count stay in the top module.

Test Plan:
1. Reset release: rst=0 for 3 cycles, then 1 -> outs_valid=0, outs=0, ins_ready=0 during reset; ins_ready=1 from the second edge after release.
2. Single token, DATA_WIDTH=32: push 0x00000039 with outs_ready=1 -> outs_valid=1 and outs=0x39 exactly one cycle later; count returns to 0 the cycle after.
3. Fill to full, NUM_SLOTS=4, outs_ready=0: push 0x39,0x3A,0x3B,0x3C -> ins_ready=0 after the 4th push; a 5th offered token is not accepted; drain yields 0x39..0x3C in order.
4. Streaming at full rate: ins_valid=1 and outs_ready=1 for 20 cycles with incrementing data -> one token out per cycle after 1-cycle fill, no gaps, count stays at 1.
5. Full plus simultaneous offer: at count=4, outs_ready=1 and ins_valid=1 -> pop only in that cycle; ins_ready=1 next cycle; count goes 4->3->4 with pop+push.
6. Mid-stream reset, NUM_SLOTS=3 (non-power-of-two): hold 2 tokens after a pointer wrap, assert rst asynchronously between edges -> outs_valid drops immediately; after release, the first new push 0x55 is the first token out.
